// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer over one shared instruction/data memory port.
// Walks FETCH/DECODE/EXEC/MEMACC/WB and traps illegal opcodes and memory timeouts into ERROR.
module multicycle_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       sign_ext,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       retire,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    localparam int CW = $clog2(TIMEOUT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_illegal;
    logic            r_timeout;
    logic            w_set_illegal;
    logic            w_set_timeout;
    logic            w_funct_ok;
    logic            w_legal;
    logic            w_is_jr;
    logic            w_timeout_hit;
    logic [2:0]      w_r_alu_op;

    assign state         = r_state;
    assign illegal_op    = r_illegal;
    assign mem_timeout   = r_timeout;
    assign w_is_jr       = (opcode == OP_RTYPE) && (funct == F_JR);
    assign w_timeout_hit = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_funct_ok = 1'b1;
        w_r_alu_op = ALU_ADD;
        case (funct)
            F_ADD:   w_r_alu_op = ALU_ADD;
            F_SUB:   w_r_alu_op = ALU_SUB;
            F_AND:   w_r_alu_op = ALU_AND;
            F_OR:    w_r_alu_op = ALU_OR;
            F_SLT:   w_r_alu_op = ALU_SLT;
            F_JR:    w_r_alu_op = ALU_ADD;
            default: w_funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            OP_RTYPE: w_legal = w_funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J, OP_JAL: w_legal = 1'b1;
            default:  w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | w_set_illegal;
            r_timeout <= r_timeout | w_set_timeout;
            // Stall counter only runs while a request waits in the same state.
            if ((r_state == S_FETCH || r_state == S_MEMACC) && !mem_ready && (w_next == r_state))
                r_cnt <= r_cnt + CW'(1);
            else
                r_cnt <= '0;
        end
    end

    // Memory handshake: mem_req stays high until mem_ready; the access completes on the cycle both are high.
    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = ALU_ADD;
        sign_ext      = 1'b1;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        retire        = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'd1;
                    w_next    = S_DECODE;
                end else if (w_timeout_hit) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_ERROR;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                if (!w_legal) begin
                    w_set_illegal = 1'b1;
                    w_next        = S_ERROR;
                end else if (opcode == OP_J || opcode == OP_JAL) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    retire   = 1'b1;
                    w_next   = S_FETCH;
                    if (opcode == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                w_next    = S_WB;
                if (w_is_jr) begin
                    alu_src_a = 1'b0;
                    pc_write  = 1'b1;
                    pc_src    = 2'd3;
                    retire    = 1'b1;
                    w_next    = S_FETCH;
                end else begin
                    case (opcode)
                        OP_RTYPE: alu_op = w_r_alu_op;
                        OP_LW, OP_SW: begin
                            alu_src_b = 2'd2;
                            w_next    = S_MEMACC;
                        end
                        OP_ADDI: alu_src_b = 2'd2;
                        OP_ORI: begin
                            alu_src_b = 2'd2;
                            alu_op    = ALU_OR;
                            sign_ext  = 1'b0;
                        end
                        OP_BEQ, OP_BNE: begin
                            alu_op   = ALU_SUB;
                            pc_src   = 2'd1;
                            retire   = 1'b1;
                            pc_write = (opcode == OP_BEQ) ? zero : ~zero;
                            w_next   = S_FETCH;
                        end
                        default: w_next = S_WB;
                    endcase
                end
            end
            S_MEMACC: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout_hit) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_ERROR;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                reg_dst    = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
                mem_to_reg = (opcode == OP_LW) ? 2'd1 : 2'd0;
                w_next     = S_FETCH;
            end
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_ERROR;
        endcase
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle traces built from the
// instruction-level behaviour table, compared against every output on every cycle.
module tb_multicycle_controller;

    localparam int TIMEOUT = 16;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101, J = 6'b000010;
    localparam logic [5:0] JAL = 6'b000011;
    localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100;
    localparam logic [5:0] FOR = 6'b100101, FSLT = 6'b101010, FJR = 6'b001000;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       sign_ext;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       retire;
        logic       illegal_op;
        logic       mem_timeout;
    } rec_t;
    localparam int RW = $bits(rec_t);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, sign_ext;
    logic       reg_write, retire, illegal_op, mem_timeout;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic [2:0] alu_op, state;
    rec_t       obs;

    logic [RW-1:0] exp_q[$];
    bit            ready_q[$];
    bit            m_ill = 1'b0;
    bit            m_tmo = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            n_fail = 0;

    logic [5:0] k_op [13] = '{RT, RT, RT, RT, RT, RT, LW, SW, BEQ, BNE, ADDI, ORI, J};
    logic [5:0] k_fn [13] = '{FADD, FSUB, FAND, FOR, FSLT, FJR, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    logic [5:0] legal_fn [6] = '{FADD, FSUB, FAND, FOR, FSLT, FJR};

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .sign_ext(sign_ext), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .retire(retire), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state(state)
    );

    assign obs = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                  alu_op, sign_ext, reg_write, reg_dst, mem_to_reg, retire, illegal_op, mem_timeout};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed state %0d expected end of test", state);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [RW-1:0] o, input logic [RW-1:0] e);
        n_checks++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h (state %0d) expected %h (state %0d)",
                   tag, o, o[RW-1 -: 3], e, e[RW-1 -: 3]);
        end
    endtask

    // A cycle where nothing is asserted: only the stated defaults apply.
    function automatic rec_t idle(input logic [2:0] s);
        rec_t r;
        r = '0;
        r.state    = s;
        r.alu_op   = 3'b010;
        r.sign_ext = 1'b1;
        return r;
    endfunction

    task automatic push(input rec_t r, input bit rdy);
        r.illegal_op  = m_ill;
        r.mem_timeout = m_tmo;
        exp_q.push_back(r);
        ready_q.push_back(rdy);
    endtask

    task automatic push_error();
        for (int i = 0; i < 3; i++) push(idle(3'd7), 1'($urandom_range(0, 1)));
    endtask

    // Stall cycles of a pending request; the 16th consecutive stall ends in a timeout.
    task automatic push_stalls(input rec_t r, input int lat, output bit to);
        to = 1'b0;
        for (int i = 0; i < lat; i++) begin
            push(r, 1'b0);
            if (i == TIMEOUT - 1) begin
                to = 1'b1;
                break;
            end
        end
        if (to) begin
            m_tmo = 1'b1;
            push_error();
        end
    endtask

    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == RT) begin
            foreach (legal_fn[i]) if (legal_fn[i] == fn) return 1'b1;
            return 1'b0;
        end
        return op inside {LW, SW, BEQ, BNE, ADDI, ORI, J, JAL};
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            FSUB:    return 3'b110;
            FAND:    return 3'b000;
            FOR:     return 3'b001;
            FSLT:    return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int flat, input int mlat);
        rec_t r;
        bit   to;
        r = idle(3'd0);
        r.mem_req = 1'b1;
        push_stalls(r, flat, to);
        if (to) return;
        r.ir_write  = 1'b1;
        r.pc_write  = 1'b1;
        r.alu_src_b = 2'd1;
        push(r, 1'b1);
        r = idle(3'd1);
        r.alu_src_b = 2'd3;
        if (!legal(op, fn)) begin
            push(r, 1'($urandom_range(0, 1)));
            m_ill = 1'b1;
            push_error();
            return;
        end
        if (op == J || op == JAL) begin
            r.pc_write = 1'b1;
            r.pc_src   = 2'd2;
            r.retire   = 1'b1;
            if (op == JAL) begin
                r.reg_write  = 1'b1;
                r.reg_dst    = 2'd2;
                r.mem_to_reg = 2'd2;
            end
            push(r, 1'($urandom_range(0, 1)));
            return;
        end
        push(r, 1'($urandom_range(0, 1)));
        r = idle(3'd2);
        if (op == RT && fn == FJR) begin
            r.pc_write = 1'b1;
            r.pc_src   = 2'd3;
            r.retire   = 1'b1;
            push(r, 1'($urandom_range(0, 1)));
            return;
        end
        r.alu_src_a = 1'b1;
        if (op == BEQ || op == BNE) begin
            r.alu_op   = 3'b110;
            r.pc_src   = 2'd1;
            r.retire   = 1'b1;
            r.pc_write = (op == BEQ) ? z : !z;
            push(r, 1'($urandom_range(0, 1)));
            return;
        end
        if (op == RT) r.alu_op = r_alu(fn);
        else r.alu_src_b = 2'd2;
        if (op == ORI) begin
            r.alu_op   = 3'b001;
            r.sign_ext = 1'b0;
        end
        push(r, 1'($urandom_range(0, 1)));
        if (op == LW || op == SW) begin
            r = idle(3'd3);
            r.mem_req = 1'b1;
            r.iord    = 1'b1;
            r.mem_we  = (op == SW);
            push_stalls(r, mlat, to);
            if (to) return;
            r.retire = (op == SW);
            push(r, 1'b1);
            if (op == SW) return;
        end
        r = idle(3'd4);
        r.reg_write  = 1'b1;
        r.retire     = 1'b1;
        r.reg_dst    = (op == RT) ? 2'd1 : 2'd0;
        r.mem_to_reg = (op == LW) ? 2'd1 : 2'd0;
        push(r, 1'($urandom_range(0, 1)));
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int flat, input int mlat);
        int c = 0;
        build(op, fn, z, flat, mlat);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            reset     = 1'b0;
            opcode    = op;
            funct     = fn;
            zero      = z;
            mem_ready = ready_q.pop_front();
            #1;
            check($sformatf("%s_c%0d", name, c), obs, exp_q.pop_front());
            c++;
        end
    endtask

    // Leaves reset asserted; the next instruction's first cycle releases it.
    task automatic do_reset(input string name);
        logic [RW-1:0] o;
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        o = '0;
        o[10:0] = {state, mem_req, mem_we, ir_write, pc_write, reg_write, retire,
                   illegal_op, mem_timeout};
        check(name, o, '0);
        m_ill = 1'b0;
        m_tmo = 1'b0;
    endtask

    initial begin
        int k;
        logic [5:0] fn;
        do_reset("reset_init");
        run_instr("add",        RT,   FADD, 1'b0, 0, 0);
        run_instr("lw_slow",    LW,   6'd0, 1'b0, 0, 3);
        run_instr("beq_taken",  BEQ,  6'd0, 1'b1, 0, 0);
        run_instr("beq_not",    BEQ,  6'd0, 1'b0, 1, 0);
        run_instr("bne_taken",  BNE,  6'd0, 1'b0, 0, 0);
        run_instr("bne_not",    BNE,  6'd0, 1'b1, 0, 0);
        run_instr("jal",        JAL,  6'd0, 1'b0, 0, 0);
        run_instr("j",          J,    6'd0, 1'b0, 2, 0);
        run_instr("jr",         RT,   FJR,  1'b0, 0, 0);
        run_instr("slt",        RT,   FSLT, 1'b0, 0, 0);
        run_instr("ori",        ORI,  6'd0, 1'b0, 0, 0);
        run_instr("addi",       ADDI, 6'd0, 1'b0, 0, 0);
        run_instr("sw",         SW,   6'd0, 1'b0, 1, 2);
        run_instr("fetch_edge", RT,   FSUB, 1'b0, TIMEOUT - 1, 0);
        run_instr("mem_edge",   SW,   6'd0, 1'b0, 0, TIMEOUT - 1);
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 13);
            if (k == 13)
                run_instr($sformatf("rnd%0d", i), JAL, 6'd0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3), 0);
            else
                run_instr($sformatf("rnd%0d", i), k_op[k], k_fn[k], 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_instr("illegal_opcode", 6'b111111, 6'd0, 1'b0, 0, 0);
        do_reset("reset_after_illegal");
        do begin
            fn = 6'($urandom_range(0, 63));
        end while (legal(RT, fn));
        run_instr("illegal_funct", RT, fn, 1'b0, 0, 0);
        do_reset("reset_after_funct");
        run_instr("fetch_timeout", RT, FADD, 1'b0, TIMEOUT + 4, 0);
        do_reset("reset_after_fetch_to");
        run_instr("mem_timeout", LW, 6'd0, 1'b0, 0, TIMEOUT + 4);
        do_reset("reset_after_mem_to");
        run_instr("post_reset_add", RT, FOR, 1'b0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
